// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command constants and sequencer state type shared by the text refresh front end.
package lcd_pkg;
    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
    localparam logic [7:0] INIT_CMD [4] = '{FUNC_SET, DISP_ON, CLEAR, ENTRY};

    typedef enum logic [2:0] {LOAD, WAIT, DELAY, NEXT, IDLE} seq_state_t;

    function automatic logic [7:0] row_cmd(input logic [1:0] r);
        return SET_DDRAM | ROW_BASE[r];
    endfunction
endpackage

// File: rtl/lcd_text_refresh_if.sv
// lcd_text_refresh_if: host write port into the character buffer.
interface lcd_text_refresh_if #(parameter int ADDR_W = 5);
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    modport master(output wr, addr, data);
    modport slave(input wr, addr, data);
endinterface

// File: rtl/LCD_Controller.sv
// LCD_Controller: single-byte HD44780 write engine; a rising iStart produces one LCD_EN pulse, then oDone.
module LCD_Controller #(
    parameter int CLK_Divide = 16
) (
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    input  logic       iCLK,
    input  logic       iRST_N,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);
    logic [4:0] Cont;
    logic [1:0] ST;
    logic       preStart, mStart;

    assign LCD_DATA = iDATA;
    assign LCD_RW   = 1'b0;
    assign LCD_RS   = iRS;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oDone    <= 1'b0;
            LCD_EN   <= 1'b0;
            preStart <= 1'b0;
            mStart   <= 1'b0;
            Cont     <= '0;
            ST       <= '0;
        end else begin
            preStart <= iStart;
            if ({preStart, iStart} == 2'b01) begin
                mStart <= 1'b1;
                oDone  <= 1'b0;
            end
            if (mStart) begin
                case (ST)
                    2'd0: ST <= 2'd1;
                    2'd1: begin
                        LCD_EN <= 1'b1;
                        ST     <= 2'd2;
                    end
                    2'd2: begin
                        if (Cont < 5'(CLK_Divide)) Cont <= Cont + 5'd1;
                        else ST <= 2'd3;
                    end
                    default: begin
                        LCD_EN <= 1'b0;
                        mStart <= 1'b0;
                        oDone  <= 1'b1;
                        Cont   <= '0;
                        ST     <= 2'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/lcd_char_buf.sv
// lcd_char_buf: character buffer with one write port and one combinational read port, reset to spaces.
module lcd_char_buf #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: runs the HD44780 init list, then redraws the ROWS x COLS buffer through LCD_Controller,
// either back to back or only after host writes have dirtied the buffer.
module lcd_text_refresh
    import lcd_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int DLY_CMD    = 262143,
    parameter int DLY_CHR    = 4095,
    parameter int REFRESH_EN = 1,
    parameter int ADDR_W     = $clog2(ROWS * COLS)
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    lcd_text_refresh_if.slave host,
    output logic       oInit_Done,
    output logic       oFrame_Done,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);
    localparam int LAST  = 4 + ROWS * (COLS + 1) - 1;
    localparam int IDX_W = $clog2(LAST + 1);
    localparam int DMAX  = DLY_CMD > DLY_CHR ? DLY_CMD : DLY_CHR;
    localparam int CNT_W = $clog2(DMAX + 1);
    localparam int COL_W = $clog2(COLS + 1);

    seq_state_t        state, nxt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        row;
    logic [COL_W-1:0]  col;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        data, rd_data, ld_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rs, ld_rs, start, start_d, dirty, init_done, ctrl_done;
    logic              is_init, row_end, last, d_last, wr_ok;

    assign wr_ok   = host.wr && {1'b0, host.addr} < (ADDR_W + 1)'(ROWS * COLS);
    assign is_init = idx < IDX_W'(4);
    assign row_end = col == COL_W'(COLS);
    assign last    = idx == IDX_W'(LAST);
    assign d_last  = cnt == CNT_W'(rs ? DLY_CHR - 1 : DLY_CMD - 1);
    assign rd_addr = ADDR_W'(int'(row) * COLS + int'(col) - 1);
    assign ld_data = is_init ? INIT_CMD[idx[1:0]] : col == '0 ? row_cmd(row) : rd_data;
    assign ld_rs   = !is_init && col != '0;

    lcd_char_buf #(.DEPTH(ROWS * COLS), .ADDR_W(ADDR_W)) u_buf (
        .iCLK, .iRST_N, .we(wr_ok), .wr_addr(host.addr), .wr_data(host.data), .rd_addr, .rd_data
    );

    LCD_Controller u_ctrl (
        .iDATA(data), .iRS(rs), .iStart(start), .oDone(ctrl_done), .iCLK, .iRST_N,
        .LCD_DATA, .LCD_RW, .LCD_EN, .LCD_RS
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= LOAD;
        else state <= nxt;
    end

    // oDone stays high from the previous byte until the controller sees the new start edge,
    // so it is trusted only once start has been high for a full cycle.
    always_comb begin
        nxt = state;
        case (state)
            LOAD:    nxt = WAIT;
            WAIT:    nxt = ctrl_done && start_d ? DELAY : WAIT;
            DELAY:   nxt = d_last ? NEXT : DELAY;
            NEXT:    nxt = !last || REFRESH_EN != 0 || dirty ? LOAD : IDLE;
            IDLE:    nxt = dirty ? LOAD : IDLE;
            default: nxt = LOAD;
        endcase
        oBusy       = state != IDLE;
        oFrame_Done = state == NEXT && last;
        oInit_Done  = init_done || (state == NEXT && idx == IDX_W'(3));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            data      <= '0;
            rs        <= 1'b0;
            start     <= 1'b0;
            start_d   <= 1'b0;
            dirty     <= 1'b1;
            init_done <= 1'b0;
        end else begin
            start_d <= start;
            if (state == LOAD) begin
                data  <= ld_data;
                rs    <= ld_rs;
                start <= 1'b1;
            end
            if (state == WAIT && nxt == DELAY) start <= 1'b0;
            cnt <= state == DELAY && !d_last ? cnt + 1'b1 : '0;
            if (state == NEXT) begin
                idx <= last ? IDX_W'(4) : idx + 1'b1;
                if (idx == IDX_W'(3)) init_done <= 1'b1;
                if (!is_init) begin
                    col <= row_end ? '0 : col + 1'b1;
                    row <= !row_end ? row : row == 2'(ROWS - 1) ? 2'd0 : row + 2'd1;
                end
            end
            // a write landing on the same edge as the frame-start clear keeps the buffer dirty
            dirty <= wr_ok || (dirty && !(state == LOAD && idx == IDX_W'(4)));
        end
    end
endmodule

// File: tb/tb_lcd_text_refresh.sv
// tb_lcd_text_refresh: directed checks of init, frame content, dirty-driven redraw, range guard and mid-run reset.
module tb_lcd_text_refresh;
    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       init_done [3], frame_done [3], busy [3], en [3], rs [3], rw [3], en_q [3];
    logic [7:0] lcd_data [3];
    logic [8:0] cap [3][$];
    logic [7:0] bm [3][80];
    int         fd_cnt [3];
    int         total = 0, bad = 0;

    typedef struct { int addr; logic [7:0] data; int off; logic [8:0] exp; } vec_t;
    typedef struct { int pos; logic [8:0] exp; } spot_t;
    vec_t  vecs [2];
    spot_t init_t [4];
    spot_t rows_b [4];

    always #5 clk = ~clk;

    lcd_text_refresh_if #(.ADDR_W(5)) if_a ();
    lcd_text_refresh_if #(.ADDR_W(7)) if_b ();
    lcd_text_refresh_if #(.ADDR_W(5)) if_c ();

    lcd_text_refresh #(.COLS(16), .ROWS(2), .DLY_CMD(8), .DLY_CHR(2), .REFRESH_EN(0)) dut_a (
        .iCLK(clk), .iRST_N(rst_n[0]), .host(if_a), .oInit_Done(init_done[0]), .oFrame_Done(frame_done[0]),
        .oBusy(busy[0]), .LCD_DATA(lcd_data[0]), .LCD_RW(rw[0]), .LCD_EN(en[0]), .LCD_RS(rs[0]));
    lcd_text_refresh #(.COLS(20), .ROWS(4), .DLY_CMD(8), .DLY_CHR(2), .REFRESH_EN(0)) dut_b (
        .iCLK(clk), .iRST_N(rst_n[1]), .host(if_b), .oInit_Done(init_done[1]), .oFrame_Done(frame_done[1]),
        .oBusy(busy[1]), .LCD_DATA(lcd_data[1]), .LCD_RW(rw[1]), .LCD_EN(en[1]), .LCD_RS(rs[1]));
    lcd_text_refresh #(.COLS(16), .ROWS(2), .DLY_CMD(8), .DLY_CHR(2), .REFRESH_EN(1)) dut_c (
        .iCLK(clk), .iRST_N(rst_n[2]), .host(if_c), .oInit_Done(init_done[2]), .oFrame_Done(frame_done[2]),
        .oBusy(busy[2]), .LCD_DATA(lcd_data[2]), .LCD_RW(rw[2]), .LCD_EN(en[2]), .LCD_RS(rs[2]));

    // every LCD_EN rising edge is one transfer, recorded as {RS, DATA}
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (en[d] && !en_q[d]) cap[d].push_back({rs[d], lcd_data[d]});
            if (frame_done[d]) fd_cnt[d]++;
            en_q[d] = en[d];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic we, input int addr, input logic [7:0] data);
        case (d)
            0: begin if_a.wr = we; if_a.addr = 5'(addr); if_a.data = data; end
            1: begin if_b.wr = we; if_b.addr = 7'(addr); if_b.data = data; end
            default: begin if_c.wr = we; if_c.addr = 5'(addr); if_c.data = data; end
        endcase
        if (we && addr < (d == 1 ? 80 : 32)) bm[d][addr] = data;
    endtask

    task automatic wr1(input int d, input int addr, input logic [7:0] data);
        @(negedge clk);
        drive(d, 1'b1, addr, data);
        @(negedge clk);
        drive(d, 1'b0, 0, 8'h00);
    endtask

    task automatic wait_idle(input int d, input int lim, input string tag);
        int n = 0;
        repeat (5) @(negedge clk);
        while (busy[d] && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (busy[d]) chk({tag, "_idle_timeout"}, 32'(busy[d]), 0);
    endtask

    task automatic wait_caps(input int d, input int want, input int lim, input string tag);
        int n = 0;
        while (cap[d].size() < want && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (cap[d].size() < want) chk({tag, "_xfer_timeout"}, cap[d].size(), want);
    endtask

    task automatic check_init(input int d, input int start);
        for (int i = 0; i < 4; i++)
            chk($sformatf("d%0d_init%0d", d, i), cap[d].size() > start + i ? cap[d][start + i] : 9'h1FF, init_t[i].exp);
    endtask

    task automatic check_frame(input int d, input int start, input int rows, input int cols);
        logic [7:0] base [4];
        int k;
        base = '{8'h00, 8'h40, 8'h14, 8'h54};
        k = start;
        if (cap[d].size() < start + rows * (cols + 1)) begin
            chk($sformatf("d%0d_frame_len", d), cap[d].size(), start + rows * (cols + 1));
            return;
        end
        for (int r = 0; r < rows; r++) begin
            chk($sformatf("d%0d_row%0d_cmd@%0d", d, r, k), cap[d][k], {1'b0, 8'h80 | base[r]});
            k++;
            for (int c = 0; c < cols; c++) begin
                chk($sformatf("d%0d_r%0dc%0d@%0d", d, r, c, k), cap[d][k], {1'b1, bm[d][r * cols + c]});
                k++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark, n;
        vecs[0] = '{0, 8'h41, 1, 9'h141};
        vecs[1] = '{31, 8'h5A, 33, 9'h15A};
        init_t  = '{'{0, 9'h038}, '{1, 9'h00C}, '{2, 9'h001}, '{3, 9'h006}};
        rows_b  = '{'{4, 9'h080}, '{25, 9'h0C0}, '{46, 9'h094}, '{67, 9'h0D4}};
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            en_q[d] = 1'b0;
            fd_cnt[d] = 0;
            drive(d, 1'b0, 0, 8'h00);
            for (int i = 0; i < 80; i++) bm[d][i] = 8'h20;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 1);
            chk($sformatf("d%0d_rst_init_done", d), 32'(init_done[d]), 0);
            chk($sformatf("d%0d_rst_frame_done", d), 32'(frame_done[d]), 0);
            chk($sformatf("d%0d_rst_en", d), 32'(en[d]), 0);
            chk($sformatf("d%0d_rst_rw", d), 32'(rw[d]), 0);
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        wr1(2, 3, 8'h55);

        // init sequence and first all-space frame, then idle
        wait_idle(0, 5000, "a_first");
        chk("a_first_len", cap[0].size(), 38);
        check_init(0, 0);
        check_frame(0, 4, 2, 16);
        chk("a_init_done", 32'(init_done[0]), 1);
        chk("a_fd_first", fd_cnt[0], 1);

        // back-to-back host writes while idle give exactly one redraw
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(0, 1'b1, vecs[i].addr, vecs[i].data);
        end
        @(negedge clk);
        drive(0, 1'b0, 0, 8'h00);
        wait_idle(0, 5000, "a_wr");
        chk("a_wr_len", cap[0].size(), 72);
        foreach (vecs[i]) chk($sformatf("a_vec%0d", i), cap[0].size() > 38 + vecs[i].off ? cap[0][38 + vecs[i].off] : 9'h1FF, vecs[i].exp);
        check_frame(0, 38, 2, 16);
        mark = cap[0].size();
        repeat (1000) @(negedge clk);
        chk("a_quiet_len", cap[0].size(), mark);
        chk("a_quiet_busy", 32'(busy[0]), 0);
        chk("a_fd_second", fd_cnt[0], 2);

        // write ahead of the scan lands in this frame and forces one more identical frame
        wr1(0, 10, 8'h43);
        wait_caps(0, 76, 3000, "a_col2");
        n = 0;
        while (en[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        wr1(0, 5, 8'h42);
        wait_idle(0, 8000, "a_mid");
        chk("a_mid_len", cap[0].size(), 140);
        chk("a_mid_col5", cap[0].size() > 78 ? cap[0][78] : 9'h1FF, 9'h142);
        check_frame(0, 72, 2, 16);
        check_frame(0, 106, 2, 16);
        chk("a_fd_mid", fd_cnt[0], 4);
        chk("a_mid_busy", 32'(busy[0]), 0);

        // 4x20 layout: row base addresses and 84-transfer frame
        wait_idle(1, 10000, "b_first");
        chk("b_first_len", cap[1].size(), 88);
        check_init(1, 0);
        foreach (rows_b[i]) chk($sformatf("b_rowcmd%0d", i), cap[1].size() > rows_b[i].pos ? cap[1][rows_b[i].pos] : 9'h1FF, rows_b[i].exp);
        check_frame(1, 4, 4, 20);
        wr1(1, 80, 8'h41);
        wr1(1, 127, 8'h41);
        repeat (300) @(negedge clk);
        chk("b_oob_busy", 32'(busy[1]), 0);
        chk("b_oob_len", cap[1].size(), 88);
        chk("b_oob_fd", fd_cnt[1], 1);
        wr1(1, 79, 8'h5A);
        wait_idle(1, 10000, "b_last");
        chk("b_last_len", cap[1].size(), 172);
        check_frame(1, 88, 4, 20);

        // continuous refresh: frames run back to back
        wait_caps(2, 72, 5000, "c_two");
        check_init(2, 0);
        check_frame(2, 4, 2, 16);
        check_frame(2, 38, 2, 16);
        chk("c_busy", 32'(busy[2]), 1);

        // reset in the middle of a row-1 scan restarts init with a blank buffer
        n = 0;
        while (((cap[2].size() - 4) % 34) < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("c_row1_reached", 32'(((cap[2].size() - 4) % 34) >= 20), 1);
        rst_n[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("c_rst_init_done", 32'(init_done[2]), 0);
        chk("c_rst_busy", 32'(busy[2]), 1);
        chk("c_rst_en", 32'(en[2]), 0);
        for (int i = 0; i < 80; i++) bm[2][i] = 8'h20;
        mark = cap[2].size();
        rst_n[2] = 1'b1;
        @(negedge clk);
        chk("c_post_init_done", 32'(init_done[2]), 0);
        wait_caps(2, mark + 38, 4000, "c_restart");
        check_init(2, mark);
        check_frame(2, mark + 4, 2, 16);
        chk("c_restart_init_done", 32'(init_done[2]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
